// File: rtl/mac_operand_sequencer.sv
// -----------------------------------------------------------------------------
// mac_operand_sequencer
//
// Purpose
//   Sequences one DSP48-style MAC lane through a dot product of len int8
//   activation/weight pairs. It reads both operand buffers, presents the
//   pairs to the MAC with clear / clock-enable / capture strobes, captures
//   the 32-bit accumulated sum, and hands it downstream on a valid/ready port.
//
// Optional feature (macro MAC_SEQ_SAT_EN)
//   Defined   : result_o is the captured sum clamped to the signed OUT_W range
//               (sign-extended to 32 bits); sat_o flags a clamp with
//               result_valid_o.
//   Undefined : result_o is the raw 32-bit sum; sat_o stays 0.
//
// Ports
//   clk_i, rst_i                clock (rising edge), synchronous active-high reset
//   start_i                     start pulse, accepted only in IDLE
//   act_base_i, wgt_base_i      buffer start addresses, latched on start
//   len_i                       number of MAC pairs, latched on start
//   act_rd_o/act_addr_o         activation buffer read strobe / address
//   act_data_i                  activation, valid 1 cycle after act_rd_o
//   wgt_rd_o/wgt_addr_o         weight buffer read strobe / address
//   wgt_data_i                  weight, valid 1 cycle after wgt_rd_o
//   dsp_enable_o                MAC clock enable
//   dsp_valid_o                 MAC output-capture strobe
//   clear_o                     MAC partial-sum clear
//   dsp_input_o, dsp_weight_o   operands A and B to the MAC
//   dsp_output_i                MAC result, valid 1 cycle after dsp_valid_o
//   result_o, result_valid_o,
//   result_ready_i              downstream result handshake
//   busy_o                      high in every state except IDLE
//   sat_o                       result was clamped
//
// Cycle plan (start sampled at the end of cycle 0, len > 0):
//   1               CLEAR    clear_o
//   2 .. len+1      FETCH    buffer reads, addresses advance
//   3 .. len+2      FETCH    operand pairs presented (one per read)
//   len+3 .. +L     DRAIN    zero operands, dsp_valid_o on the last one
//   len+3+L         CAPTURE  dsp_output_i loaded
//   len+4+L         OUTPUT   result_valid_o
// -----------------------------------------------------------------------------
module mac_operand_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int LEN_W   = 8,
    parameter int DSP_LAT = 3,
    parameter int OUT_W   = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   act_base_i,
    input  logic [ADDR_W-1:0]   wgt_base_i,
    input  logic [LEN_W-1:0]    len_i,
    output logic                act_rd_o,
    output logic [ADDR_W-1:0]   act_addr_o,
    input  logic signed [7:0]   act_data_i,
    output logic                wgt_rd_o,
    output logic [ADDR_W-1:0]   wgt_addr_o,
    input  logic signed [7:0]   wgt_data_i,
    output logic                dsp_enable_o,
    output logic                dsp_valid_o,
    output logic                clear_o,
    output logic signed [7:0]   dsp_input_o,
    output logic signed [7:0]   dsp_weight_o,
    input  logic signed [31:0]  dsp_output_i,
    output logic signed [31:0]  result_o,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic                busy_o,
    output logic                sat_o
);

    // The drain counter shares the length counter, so DSP_LAT must fit in it.
    if (DSP_LAT < 1 || DSP_LAT >= (1 << LEN_W)) begin : g_bad_dsp_lat
        $error("DSP_LAT out of range for LEN_W");
    end
    if (OUT_W < 2 || OUT_W > 32) begin : g_bad_out_w
        $error("OUT_W must be within 2..32");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FETCH,
        ST_DRAIN,
        ST_CAPTURE,
        ST_OUTPUT
    } state_t;

    localparam logic [LEN_W-1:0] DRAIN_LAST = LEN_W'(DSP_LAT - 1);

    state_t               state_q;
    logic [ADDR_W-1:0]    act_addr_q;
    logic [ADDR_W-1:0]    wgt_addr_q;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     cnt_q;
    logic                 rd_q;
    logic                 op_vld_q;
    logic                 dsp_enable_q;
    logic                 dsp_valid_q;
    logic                 clear_q;
    logic signed [31:0]   result_q;
    logic                 result_valid_q;
    logic                 sat_q;

    logic [LEN_W:0]       cnt_inc_d;
    logic signed [31:0]   capture_val_d;
    logic                 capture_sat_d;

    assign cnt_inc_d = {1'b0, cnt_q} + 1'b1;

`ifdef MAC_SEQ_SAT_EN
    localparam logic signed [31:0] SAT_MAX = (32'sd1 <<< (OUT_W - 1)) - 32'sd1;
    localparam logic signed [31:0] SAT_MIN = -(32'sd1 <<< (OUT_W - 1));

    always_comb begin
        capture_val_d = dsp_output_i;
        capture_sat_d = 1'b0;
        if (dsp_output_i > SAT_MAX) begin
            capture_val_d = SAT_MAX;
            capture_sat_d = 1'b1;
        end else if (dsp_output_i < SAT_MIN) begin
            capture_val_d = SAT_MIN;
            capture_sat_d = 1'b1;
        end
    end
`else
    assign capture_val_d = dsp_output_i;
    assign capture_sat_d = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            act_addr_q     <= '0;
            wgt_addr_q     <= '0;
            len_q          <= '0;
            cnt_q          <= '0;
            rd_q           <= 1'b0;
            op_vld_q       <= 1'b0;
            dsp_enable_q   <= 1'b0;
            dsp_valid_q    <= 1'b0;
            clear_q        <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            sat_q          <= 1'b0;
        end else begin
            // Buffer data shows up the cycle after its read strobe.
            op_vld_q <= rd_q;

            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        act_addr_q <= act_base_i;
                        wgt_addr_q <= wgt_base_i;
                        len_q      <= len_i;
                        if (len_i == '0) begin
                            // Empty vector: nothing to accumulate, report 0.
                            result_q       <= '0;
                            sat_q          <= 1'b0;
                            result_valid_q <= 1'b1;
                            state_q        <= ST_OUTPUT;
                        end else begin
                            clear_q <= 1'b1;
                            state_q <= ST_CLEAR;
                        end
                    end
                end

                ST_CLEAR: begin
                    clear_q <= 1'b0;
                    rd_q    <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= ST_FETCH;
                end

                ST_FETCH: begin
                    if (rd_q) begin
                        // Addresses wrap naturally at 2^ADDR_W.
                        act_addr_q   <= act_addr_q + 1'b1;
                        wgt_addr_q   <= wgt_addr_q + 1'b1;
                        cnt_q        <= cnt_inc_d[LEN_W-1:0];
                        rd_q         <= (cnt_inc_d < {1'b0, len_q});
                        dsp_enable_q <= 1'b1;
                    end else begin
                        // Reads are done and the final pair is on the MAC
                        // inputs this cycle; flush the pipeline with zeros.
                        cnt_q        <= '0;
                        dsp_enable_q <= 1'b1;
                        dsp_valid_q  <= (DSP_LAT == 1);
                        state_q      <= ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    if (cnt_q == DRAIN_LAST) begin
                        dsp_enable_q <= 1'b0;
                        dsp_valid_q  <= 1'b0;
                        state_q      <= ST_CAPTURE;
                    end else begin
                        cnt_q       <= cnt_inc_d[LEN_W-1:0];
                        dsp_valid_q <= (cnt_inc_d == {1'b0, DRAIN_LAST});
                    end
                end

                ST_CAPTURE: begin
                    result_q       <= capture_val_d;
                    sat_q          <= capture_sat_d;
                    result_valid_q <= 1'b1;
                    state_q        <= ST_OUTPUT;
                end

                ST_OUTPUT: begin
                    // start_i is deliberately not looked at here, even on
                    // the handshake cycle.
                    if (result_ready_i) begin
                        result_valid_q <= 1'b0;
                        sat_q          <= 1'b0;
                        state_q        <= ST_IDLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign act_rd_o       = rd_q;
    assign wgt_rd_o       = rd_q;
    assign act_addr_o     = act_addr_q;
    assign wgt_addr_o     = wgt_addr_q;
    // The buffers' output registers act as the operand registers; gating with
    // the delayed strobe feeds the MAC zeros whenever no pair is in flight.
    assign dsp_input_o    = op_vld_q ? act_data_i : 8'sd0;
    assign dsp_weight_o   = op_vld_q ? wgt_data_i : 8'sd0;
    assign dsp_enable_o   = dsp_enable_q;
    assign dsp_valid_o    = dsp_valid_q;
    assign clear_o        = clear_q;
    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;
    assign busy_o         = (state_q != ST_IDLE);
    assign sat_o          = sat_q;

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mac_operand_sequencer
//
// Directed bench for mac_operand_sequencer. Models the two synchronous operand
// buffers and a MAC lane with a 3-cycle operand-to-sum latency plus an output
// register loaded by dsp_valid_o. Expected sums are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mac_operand_sequencer;

    localparam int ADDR_W  = 8;
    localparam int LEN_W   = 8;
    localparam int DSP_LAT = 3;
    localparam int OUT_W   = 16;

    logic                clk_i = 1'b0;
    logic                rst_i = 1'b1;
    logic                start_i = 1'b0;
    logic [ADDR_W-1:0]   act_base_i = '0;
    logic [ADDR_W-1:0]   wgt_base_i = '0;
    logic [LEN_W-1:0]    len_i = '0;
    logic                act_rd_o;
    logic [ADDR_W-1:0]   act_addr_o;
    logic signed [7:0]   act_data_i = '0;
    logic                wgt_rd_o;
    logic [ADDR_W-1:0]   wgt_addr_o;
    logic signed [7:0]   wgt_data_i = '0;
    logic                dsp_enable_o;
    logic                dsp_valid_o;
    logic                clear_o;
    logic signed [7:0]   dsp_input_o;
    logic signed [7:0]   dsp_weight_o;
    logic signed [31:0]  dsp_output_i = '0;
    logic signed [31:0]  result_o;
    logic                result_valid_o;
    logic                result_ready_i = 1'b1;
    logic                busy_o;
    logic                sat_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    mac_operand_sequencer #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W),
        .DSP_LAT(DSP_LAT),
        .OUT_W  (OUT_W)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .act_base_i    (act_base_i),
        .wgt_base_i    (wgt_base_i),
        .len_i         (len_i),
        .act_rd_o      (act_rd_o),
        .act_addr_o    (act_addr_o),
        .act_data_i    (act_data_i),
        .wgt_rd_o      (wgt_rd_o),
        .wgt_addr_o    (wgt_addr_o),
        .wgt_data_i    (wgt_data_i),
        .dsp_enable_o  (dsp_enable_o),
        .dsp_valid_o   (dsp_valid_o),
        .clear_o       (clear_o),
        .dsp_input_o   (dsp_input_o),
        .dsp_weight_o  (dsp_weight_o),
        .dsp_output_i  (dsp_output_i),
        .result_o      (result_o),
        .result_valid_o(result_valid_o),
        .result_ready_i(result_ready_i),
        .busy_o        (busy_o),
        .sat_o         (sat_o)
    );

    // ---------------- operand buffers (registered read) ----------------
    logic signed [7:0] act_mem [256];
    logic signed [7:0] wgt_mem [256];

    always @(posedge clk_i) begin
        if (act_rd_o) act_data_i <= act_mem[act_addr_o];
        if (wgt_rd_o) wgt_data_i <= wgt_mem[wgt_addr_o];
    end

    // ---------------- MAC lane model (3-cycle latency) ----------------
    logic signed [31:0] mac_p0 = '0;
    logic signed [31:0] mac_p1 = '0;
    logic signed [31:0] mac_acc = '0;

    always @(posedge clk_i) begin
        if (clear_o) begin
            mac_p0  <= '0;
            mac_p1  <= '0;
            mac_acc <= '0;
        end else if (dsp_enable_o) begin
            mac_p0  <= dsp_input_o * dsp_weight_o;
            mac_p1  <= mac_p0;
            mac_acc <= mac_acc + mac_p1;
        end
        if (dsp_valid_o) dsp_output_i <= mac_acc;
    end

    // ---------------- activity monitor ----------------
    int n_clear = 0;
    int n_overlap = 0;
    int n_rd = 0;
    int n_en = 0;
    logic [7:0] addr_log [$];

    always @(negedge clk_i) begin
        if (clear_o) n_clear++;
        if (clear_o && dsp_valid_o) n_overlap++;
        if (act_rd_o) begin
            n_rd++;
            addr_log.push_back(act_addr_o);
        end
        if (dsp_enable_o) n_en++;
    end

    // Drives one start pulse from a negedge in IDLE and returns the cycle
    // number (start cycle = 0) in which result_valid_o is first seen.
    task automatic run_vec(input logic [7:0] ab, input logic [7:0] wb,
                           input logic [7:0] ln, output int lat);
        act_base_i = ab;
        wgt_base_i = wb;
        len_i      = ln;
        start_i    = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        lat = 1;
        while (result_valid_o !== 1'b1 && lat < 600) begin
            @(negedge clk_i);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({act_rd_o, wgt_rd_o, act_addr_o, wgt_addr_o, dsp_enable_o, dsp_valid_o,
             clear_o, dsp_input_o, dsp_weight_o, result_o, result_valid_o, busy_o, sat_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rd=%b addr=%0d en=%b clr=%b res=%0d vld=%b busy=%b required all zero",
                     act_rd_o, act_addr_o, dsp_enable_o, clear_o, result_o, result_valid_o, busy_o);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0 || result_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b valid=%b required 0 0", busy_o, result_valid_o);
        end
        $display("reset: outputs checked");
    endtask

    task automatic test_dot_basic();
        int lat, c0, ov0, r0, e0;
        result_ready_i = 1'b1;
        c0 = n_clear; ov0 = n_overlap; r0 = n_rd; e0 = n_en;
        run_vec(8'd16, 8'd32, 8'd4, lat);
        checks++;
        if (lat != 4 + 4 + DSP_LAT) begin
            errors++;
            $display("FAIL basic_latency: got %0d required %0d", lat, 4 + 4 + DSP_LAT);
        end
        checks++;
        if (result_o !== 32'sd70 || sat_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got %0d sat=%b required 70 sat=0", result_o, sat_o);
        end
        checks++;
        if (n_clear - c0 != 1 || n_overlap - ov0 != 0) begin
            errors++;
            $display("FAIL basic_clear: clear cycles %0d overlaps %0d required 1 0",
                     n_clear - c0, n_overlap - ov0);
        end
        checks++;
        if (n_rd - r0 != 4 || n_en - e0 != 4 + DSP_LAT) begin
            errors++;
            $display("FAIL basic_activity: reads %0d enables %0d required 4 %0d",
                     n_rd - r0, n_en - e0, 4 + DSP_LAT);
        end
        @(negedge clk_i);
        checks++;
        if (result_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_handshake: valid=%b busy=%b required 0 0", result_valid_o, busy_o);
        end
        $display("basic: len=4 result=%0d latency=%0d", result_o, lat);
    endtask

    // Starts immediately after the previous transfer, with a wrapping base.
    task automatic test_addr_wrap();
        int lat, idx;
        logic [7:0] exp_addr [4];
        exp_addr[0] = 8'd254; exp_addr[1] = 8'd255; exp_addr[2] = 8'd0; exp_addr[3] = 8'd1;
        idx = addr_log.size();
        run_vec(8'd254, 8'd10, 8'd4, lat);
        checks++;
        if (addr_log.size() - idx != 4) begin
            errors++;
            $display("FAIL wrap_count: got %0d reads required 4", addr_log.size() - idx);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (addr_log[idx + i] !== exp_addr[i]) begin
                    errors++;
                    $display("FAIL wrap_addr%0d: got %0d required %0d", i, addr_log[idx + i], exp_addr[i]);
                end
            end
        end
        checks++;
        if (result_o !== -32'sd42 || lat != 4 + 4 + DSP_LAT) begin
            errors++;
            $display("FAIL wrap_result: got %0d lat %0d required -42 lat %0d", result_o, lat, 4 + 4 + DSP_LAT);
        end
        @(negedge clk_i);
        $display("wrap: base=254 result=%0d", result_o);
    endtask

    task automatic test_saturate();
        int lat;
        logic signed [31:0] exp_res;
        logic exp_sat;
`ifdef MAC_SEQ_SAT_EN
        exp_res = 32'sd32767;
        exp_sat = 1'b1;
`else
        exp_res = 32'sd262144;
        exp_sat = 1'b0;
`endif
        run_vec(8'd64, 8'd128, 8'd16, lat);
        checks++;
        if (result_o !== exp_res || sat_o !== exp_sat) begin
            errors++;
            $display("FAIL sat_result: got %0d sat=%b required %0d sat=%b", result_o, sat_o, exp_res, exp_sat);
        end
        checks++;
        if (lat != 16 + 4 + DSP_LAT) begin
            errors++;
            $display("FAIL sat_latency: got %0d required %0d", lat, 16 + 4 + DSP_LAT);
        end
        @(negedge clk_i);
        checks++;
        if (sat_o !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear: sat=%b after transfer required 0", sat_o);
        end
        $display("saturate: len=16 result=%0d", exp_res);
    endtask

    task automatic test_zero_len();
        int lat, r0, e0, c0;
        r0 = n_rd; e0 = n_en; c0 = n_clear;
        run_vec(8'd0, 8'd0, 8'd0, lat);
        checks++;
        if (lat != 1 || result_o !== 32'sd0) begin
            errors++;
            $display("FAIL zero_len: lat %0d result %0d required 1 0", lat, result_o);
        end
        @(negedge clk_i);
        checks++;
        if (n_rd - r0 != 0 || n_en - e0 != 0 || n_clear - c0 != 0) begin
            errors++;
            $display("FAIL zero_activity: reads %0d enables %0d clears %0d required 0 0 0",
                     n_rd - r0, n_en - e0, n_clear - c0);
        end
        $display("zero_len: result=%0d latency=%0d", result_o, lat);
    endtask

    task automatic test_stall();
        int lat;
        result_ready_i = 1'b0;
        run_vec(8'd16, 8'd32, 8'd4, lat);
        for (int i = 0; i < 5; i++) begin
            start_i = (i == 2);
            len_i   = 8'd0;
            @(negedge clk_i);
            checks++;
            if (result_valid_o !== 1'b1 || result_o !== 32'sd70 || busy_o !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold%0d: valid=%b result=%0d busy=%b required 1 70 1",
                         i, result_valid_o, result_o, busy_o);
            end
        end
        // Start coincident with the handshake must be dropped.
        start_i = 1'b1;
        len_i = 8'd4;
        result_ready_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        checks++;
        if (result_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: valid=%b busy=%b required 0 0", result_valid_o, busy_o);
        end
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0 || clear_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_ignored_start: busy=%b clear=%b required 0 0", busy_o, clear_o);
        end
        $display("stall: result held at %0d for 5 cycles", result_o);
    endtask

    task automatic test_reset_mid_fetch();
        int lat, wait_cnt;
        act_base_i = 8'd64;
        wgt_base_i = 8'd128;
        len_i = 8'd16;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_cnt = 0;
        while (act_rd_o !== 1'b1 && wait_cnt < 20) begin
            @(negedge clk_i);
            wait_cnt++;
        end
        checks++;
        if (act_rd_o !== 1'b1) begin
            errors++;
            $display("FAIL midreset_fetch: act_rd=%b required 1", act_rd_o);
        end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({act_rd_o, wgt_rd_o, act_addr_o, wgt_addr_o, dsp_enable_o, dsp_valid_o,
             clear_o, dsp_input_o, dsp_weight_o, result_o, result_valid_o, busy_o, sat_o} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: rd=%b addr=%0d en=%b in=%0d res=%0d busy=%b required all zero",
                     act_rd_o, act_addr_o, dsp_enable_o, dsp_input_o, result_o, busy_o);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
        run_vec(8'd16, 8'd32, 8'd4, lat);
        checks++;
        if (result_o !== 32'sd70 || lat != 4 + 4 + DSP_LAT) begin
            errors++;
            $display("FAIL midreset_fresh: got %0d lat %0d required 70 lat %0d", result_o, lat, 4 + 4 + DSP_LAT);
        end
        @(negedge clk_i);
        $display("reset_mid_fetch: fresh result=%0d", result_o);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            act_mem[i] = 8'sd0;
            wgt_mem[i] = 8'sd0;
        end
        // basic vector: 1*5 + 2*6 + 3*7 + 4*8 = 70
        act_mem[16] = 8'sd1; act_mem[17] = 8'sd2; act_mem[18] = 8'sd3; act_mem[19] = 8'sd4;
        wgt_mem[32] = 8'sd5; wgt_mem[33] = 8'sd6; wgt_mem[34] = 8'sd7; wgt_mem[35] = 8'sd8;
        // wrap vector: 3*4 + (-2)*5 + 7*(-6) + (-1)*2 = -42
        act_mem[254] = 8'sd3; act_mem[255] = -8'sd2; act_mem[0] = 8'sd7; act_mem[1] = -8'sd1;
        wgt_mem[10] = 8'sd4; wgt_mem[11] = 8'sd5; wgt_mem[12] = -8'sd6; wgt_mem[13] = 8'sd2;
        // saturation vector: 16 * (-128 * -128) = 262144
        for (int i = 0; i < 16; i++) begin
            act_mem[64 + i]  = -8'sd128;
            wgt_mem[128 + i] = -8'sd128;
        end

        @(negedge clk_i);
        test_reset();
        test_dot_basic();
        test_addr_wrap();
        test_saturate();
        test_zero_len();
        test_stall();
        test_reset_mid_fetch();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
